// File: rtl/piano_pkg.sv
// Shared definitions for the melody player: note codes, tone frequencies,
// controller states and the melody ROM image.
package piano_pkg;

    typedef enum logic [2:0] {
        NOTE_REST = 3'd0,
        NOTE_C4   = 3'd1,
        NOTE_F4   = 3'd2,
        NOTE_G4   = 3'd3,
        NOTE_A4   = 3'd4,
        NOTE_END  = 3'd7
    } note_e;

    localparam int unsigned FREQ_C4 = 262;
    localparam int unsigned FREQ_F4 = 349;
    localparam int unsigned FREQ_G4 = 392;
    localparam int unsigned FREQ_A4 = 440;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_NOTE,
        S_GAP,
        S_FINISH
    } state_e;

    localparam int unsigned ROM_DEPTH = 16;

    // Each entry is {note, len}; len n plays for n+1 beats.
    localparam logic [4:0] MELODY_ROM [ROM_DEPTH] = '{
        {NOTE_C4,   2'd0}, {NOTE_C4,  2'd0}, {NOTE_G4,  2'd0}, {NOTE_G4,  2'd0},
        {NOTE_A4,   2'd0}, {NOTE_A4,  2'd0}, {NOTE_G4,  2'd1}, {NOTE_F4,  2'd0},
        {NOTE_F4,   2'd0}, {NOTE_REST, 2'd0}, {NOTE_C4, 2'd1}, {NOTE_END, 2'd0},
        {NOTE_END,  2'd0}, {NOTE_END, 2'd0}, {NOTE_END, 2'd0}, {NOTE_END, 2'd0}
    };

    // Half-period count for a square wave of freq_hz; evaluated at elaboration only.
    function automatic int unsigned half_period(input int unsigned clk_hz,
                                                input int unsigned freq_hz);
        return clk_hz / freq_hz / 2 - 1;
    endfunction

endpackage

// File: rtl/melody_rom.sv
// Combinational melody lookup: 4-bit entry index to {note, len}.
module melody_rom
    import piano_pkg::*;
(
    input  logic [3:0] idx,
    output note_e      note,
    output logic [1:0] len
);

    logic [4:0] entry;

    always_comb begin
        entry = MELODY_ROM[idx];
        note  = note_e'(entry[4:2]);
        len   = entry[1:0];
    end

endmodule

// File: rtl/melody_player.sv
// Plays the ROM melody as a sequence of tone half-period counts with a
// silent gap after every note; start/stop controlled, done pulses on completion.
module melody_player
    import piano_pkg::*;
#(
    parameter int unsigned INPUT   = 50_000_000,
    parameter int unsigned WIDTH   = 24,
    parameter int unsigned BEAT_MS = 250,
    parameter int unsigned GAP_MS  = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] tone,
    output logic             mute
);

    localparam int unsigned MS_CYC = INPUT / 1000;

    localparam logic [WIDTH-1:0] TONE_C4 = WIDTH'(half_period(INPUT, FREQ_C4));
    localparam logic [WIDTH-1:0] TONE_F4 = WIDTH'(half_period(INPUT, FREQ_F4));
    localparam logic [WIDTH-1:0] TONE_G4 = WIDTH'(half_period(INPUT, FREQ_G4));
    localparam logic [WIDTH-1:0] TONE_A4 = WIDTH'(half_period(INPUT, FREQ_A4));

    state_e           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [1:0]       len_q, len_d;
    logic [31:0]      pre_q, pre_d;
    logic [31:0]      ms_q, ms_d;
    logic [WIDTH-1:0] tone_q, tone_d;
    logic             mute_q, mute_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    note_e            rom_note;
    logic [1:0]       rom_len;
    logic [WIDTH-1:0] rom_tone;
    logic [31:0]      note_ms;
    logic             ms_tick;

    melody_rom u_rom (
        .idx  (idx_q),
        .note (rom_note),
        .len  (rom_len)
    );

    always_comb begin
        case (rom_note)
            NOTE_C4: rom_tone = TONE_C4;
            NOTE_F4: rom_tone = TONE_F4;
            NOTE_G4: rom_tone = TONE_G4;
            NOTE_A4: rom_tone = TONE_A4;
            default: rom_tone = '0;
        endcase
    end

    assign note_ms = (32'(len_q) + 32'd1) * BEAT_MS;
    assign ms_tick = (pre_q == MS_CYC - 1);

    // NOTE: every signal written here gets a default first, so no latches are inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        pre_d   = pre_q;
        ms_d    = ms_q;
        tone_d  = tone_q;
        mute_d  = mute_q;

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                    mute_d  = 1'b1;
                end
            end
            S_LOAD: begin
                pre_d = '0;
                ms_d  = '0;
                if (rom_note == NOTE_END) begin
                    state_d = S_FINISH;
                    tone_d  = '0;
                    mute_d  = 1'b1;
                end else begin
                    state_d = S_NOTE;
                    len_d   = rom_len;
                    tone_d  = rom_tone;
                    mute_d  = (rom_tone == '0);
                end
            end
            S_NOTE: begin
                pre_d = ms_tick ? '0 : pre_q + 32'd1;
                if (ms_tick) begin
                    if (ms_q == note_ms - 32'd1) begin
                        state_d = S_GAP;
                        ms_d    = '0;
                        mute_d  = 1'b1;
                    end else begin
                        ms_d = ms_q + 32'd1;
                    end
                end
            end
            S_GAP: begin
                pre_d = ms_tick ? '0 : pre_q + 32'd1;
                if (ms_tick) begin
                    if (ms_q == GAP_MS - 1) begin
                        ms_d  = '0;
                        idx_d = idx_q + 4'd1;
                        // Wrapping past the last entry ends the melody like an END code.
                        if (idx_q == 4'hF) begin
                            state_d = S_FINISH;
                            tone_d  = '0;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end else begin
                        ms_d = ms_q + 32'd1;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (stop && state_q != S_IDLE) begin
            state_d = S_IDLE;
            pre_d   = '0;
            ms_d    = '0;
            tone_d  = '0;
            mute_d  = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FINISH);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            pre_q   <= '0;
            ms_q    <= '0;
            tone_q  <= '0;
            mute_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            pre_q   <= pre_d;
            ms_q    <= ms_d;
            tone_q  <= tone_d;
            mute_q  <= mute_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign tone = tone_q;
    assign mute = mute_q;

endmodule

// File: tb/tb_melody_player.sv
// Scoreboard bench for melody_player at INPUT=8000, BEAT_MS=2, GAP_MS=1
// (beat = 16 cycles, gap = 8 cycles, C4=14 F4=10 G4=9 A4=8).
module tb_melody_player;

    localparam int W = 24;

    typedef struct packed {
        logic         busy;
        logic         done;
        logic         mute;
        logic [W-1:0] tone;
    } exp_t;

    localparam int NUM_NOTES = 11;
    localparam int MEL_TONE  [NUM_NOTES] = '{14, 14, 9, 9, 8, 8, 9, 10, 10, 0, 14};
    localparam int MEL_BEATS [NUM_NOTES] = '{1, 1, 1, 1, 1, 1, 2, 1, 1, 1, 2};
    localparam int MEL_REST  [NUM_NOTES] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         stop;
    logic         busy;
    logic         done;
    logic [W-1:0] tone;
    logic         mute;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   play_cyc = 0;
    int   done_cnt = 0;
    int   done_at = -1;
    int   model_tone = 0;
    int   gen_cyc;
    int   gen_stop;
    bit   gen_halt;

    melody_player #(
        .INPUT   (8000),
        .WIDTH   (W),
        .BEAT_MS (2),
        .GAP_MS  (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .stop  (stop),
        .busy  (busy),
        .done  (done),
        .tone  (tone),
        .mute  (mute)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0d expected %0d", tag, play_cyc, got, exp);
        end
    endtask

    // Appends the expectation for the next cycle; a stop sampled at the end of
    // cycle gen_stop turns cycle gen_stop+1 idle and truncates the trace.
    task automatic put(input logic b, input logic d, input logic m, input int t);
        exp_t e;
        if (gen_halt) return;
        if (gen_stop > 0 && gen_cyc == gen_stop + 1) begin
            e = '{busy: 1'b0, done: 1'b0, mute: 1'b1, tone: '0};
            exp_q.push_back(e);
            gen_halt   = 1'b1;
            model_tone = 0;
            return;
        end
        e = '{busy: b, done: d, mute: m, tone: W'(t)};
        exp_q.push_back(e);
        gen_cyc++;
    endtask

    task automatic expect_play(input int stop_at);
        gen_cyc  = 0;
        gen_halt = 1'b0;
        gen_stop = stop_at;
        put(1'b0, 1'b0, 1'b1, model_tone);
        for (int e = 0; e <= NUM_NOTES; e++) begin
            put(1'b1, 1'b0, 1'b1, model_tone);
            if (e == NUM_NOTES) begin
                put(1'b1, 1'b1, 1'b1, 0);
                break;
            end
            if (!gen_halt) model_tone = MEL_TONE[e];
            for (int k = 0; k < MEL_BEATS[e] * 16; k++)
                put(1'b1, 1'b0, MEL_REST[e] != 0, MEL_TONE[e]);
            for (int k = 0; k < 8; k++)
                put(1'b1, 1'b0, 1'b1, MEL_TONE[e]);
        end
        put(1'b0, 1'b0, 1'b1, 0);
        model_tone = 0;
    endtask

    task automatic push_idle(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e = '{busy: 1'b0, done: 1'b0, mute: 1'b1, tone: W'(model_tone)};
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget && exp_q.size() > 0; c++) @(posedge clk);
        #1;
        check("drain", exp_q.size(), 0);
    endtask

    // Start in cycle 0, optional stop / repeated start in later cycles.
    task automatic run_play(input int stop_at, input int restart_at);
        @(posedge clk);
        #1;
        play_cyc = 0;
        done_cnt = 0;
        done_at  = -1;
        expect_play(stop_at);
        start = 1'b1;
        for (int c = 1; c < 600 && exp_q.size() > 0; c++) begin
            @(posedge clk);
            #1;
            play_cyc = c;
            start    = (c == restart_at);
            stop     = (stop_at > 0 && c == stop_at);
        end
        start = 1'b0;
        stop  = 1'b0;
        check("drain", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            done_cnt++;
            done_at = play_cyc;
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("busy", 32'(busy), 32'(e.busy));
            check("done", 32'(done), 32'(e.done));
            check("mute", 32'(mute), 32'(e.mute));
            check("tone", 32'(tone), 32'(e.tone));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        #12;
        check("rst_tone", 32'(tone), 0);
        check("rst_mute", 32'(mute), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_tone = 0;
        push_idle(2);
        drain(10);

        // Full melody with a start attempt while busy.
        run_play(0, 5);
        check("done_cnt", done_cnt, 1);
        check("done_at", done_at, 309);

        // Stop mid-note.
        run_play(10, 0);
        check("stop_done_cnt", done_cnt, 0);

        // start and stop together in IDLE.
        @(posedge clk);
        #1;
        push_idle(3);
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        drain(10);

        // Asynchronous reset in the middle of the first note.
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("pre_rst_tone", 32'(tone), 14);
        check("pre_rst_mute", 32'(mute), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_tone", 32'(tone), 0);
        check("async_mute", 32'(mute), 1);
        check("async_busy", 32'(busy), 0);
        check("async_done", 32'(done), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_tone = 0;

        // Replay from entry 0 after the reset.
        run_play(0, 0);
        check("replay_done_cnt", done_cnt, 1);
        check("replay_done_at", done_at, 309);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/melody_player.md
MELODY_PLAYER -- requirements
Module: melody_player

Interface
REQ-001 SHALL have parameter INPUT, default 50_000_000, meaning clock frequency in Hz.
REQ-002 SHALL have parameter WIDTH, default 24, meaning width of the tone half-period count.
REQ-003 SHALL have parameter BEAT_MS, default 250, meaning one beat length in ms.
REQ-004 SHALL have parameter GAP_MS, default 20, meaning the silent gap after each note in ms.
REQ-005 SHALL have port clk, input, 1, the single clock for all logic.
REQ-006 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-007 SHALL have port start, input, 1, a request to play the melody from entry 0.
REQ-008 SHALL have port stop, input, 1, a request to abort playback.
REQ-009 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-010 SHALL have port done, output, 1, a one-cycle pulse when the melody completes normally.
REQ-011 SHALL have port tone, output, WIDTH, the half-period count for the downstream square-wave divider.
REQ-012 SHALL have port mute, output, 1, which silences the tone generator when high.

Function
REQ-013 SHALL compute each tone constant as INPUT/f/2-1, using integer division, truncated to WIDTH bits, for C4=262, F4=349, G4=392 and A4=440 Hz.
REQ-014 SHALL read a 16-entry ROM whose entries are {note[2:0], len[1:0]}, with note codes 0=REST, 1=C4, 2=F4, 3=G4, 4=A4, 7=END, and len n meaning n+1 beats.
REQ-015 SHALL contain this ROM: C4/0, C4/0, G4/0, G4/0, A4/0, A4/0, G4/1, F4/0, F4/0, REST/0, C4/1, with entries 11..15 set to END.
REQ-016 SHALL implement the FSM states IDLE, LOAD, NOTE, GAP and FINISH.
REQ-017 IDLE SHALL move to LOAD with idx=0 when start=1 and stop=0, and otherwise SHALL remain in IDLE.
REQ-018 LOAD SHALL last exactly one cycle with mute=1, and SHALL go to FINISH if note=END, otherwise to NOTE.
REQ-019 On the LOAD->NOTE transition, tone and mute SHALL be registered so they are valid from the first NOTE cycle (tone=0 and mute=1 for REST).
REQ-020 NOTE SHALL last exactly (len+1)*BEAT_MS*(INPUT/1000) cycles, then go to GAP.
REQ-021 GAP SHALL last exactly GAP_MS*(INPUT/1000) cycles with mute=1 and tone held, then increment idx and go to LOAD.
REQ-022 If idx wraps from 15 to 0, GAP SHALL go to FINISH instead of LOAD.
REQ-023 FINISH SHALL assert done for one cycle, set tone=0 and mute=1, then go to IDLE.
REQ-024 The ms prescaler and the beat/ms counters SHALL clear on entry to NOTE and on entry to GAP, with no drift carried between phases.
REQ-025 stop=1 in any state other than IDLE SHALL force IDLE on the next edge with tone=0, mute=1 and no done pulse.
REQ-026 stop SHALL take priority over start and over every timer expiry.
REQ-027 start while busy SHALL be ignored, with no restart.
REQ-028 Start-to-first-audible latency SHALL be 2 cycles: the sampling edge, then LOAD, then NOTE.

Reset
REQ-029 While rst_n=0, the block SHALL asynchronously force state=IDLE, idx=0, counters=0, tone=0, mute=1, busy=0 and done=0.
REQ-030 After rst_n deasserts, the block SHALL act on the first start sampled at a clk edge.
REQ-031 Reset asserted mid-note SHALL abort playback immediately, regardless of clk.

Structure
REQ-032 Shared package piano_pkg SHALL hold the note codes, the FREQ_* constants, the state enum and the ROM contents constant.
REQ-033 The design SHALL have a single sub-module, melody_rom: a combinational lookup from 4-bit idx to {note, len}.
REQ-034 Tone constant computation SHALL be elaborated from parameters, with no runtime dividers.

Verification (INPUT=8000, BEAT_MS=2, GAP_MS=1: ms=8, beat=16, gap=8 cycles; C4=14, F4=10, G4=9, A4=8)
REQ-035 Scenario "reset": rst_n low -> tone=0, mute=1, busy=0, done=0; still true one cycle after release with start=0.
REQ-036 Scenario "first note": start pulse at edge 0 -> busy=1 from cycle 1; tone=14 and mute=0 during cycles 2..17; mute=1 during cycles 18..25; LOAD at cycle 26; tone=14 and mute=0 again from cycle 27.
REQ-037 Scenario "full melody": one start -> the tone sequence 14,14,9,9,8,8,9,10,10,REST(mute),14 appears in order; the single done pulse occurs at cycle 309; busy=0 from cycle 310.
REQ-038 Scenario "stop mid-note": stop at cycle 10 -> mute=1, tone=0 and busy=0 at cycle 11; done never asserts.
REQ-039 Scenario "start contention": start at cycle 5 during playback -> timing is identical to the "first note" scenario. start and stop together in IDLE -> busy stays 0.
REQ-040 Scenario "async reset": rst_n low mid-NOTE, between clk edges -> mute=1 and tone=0 without waiting for a clk edge; the next start replays from entry 0.
